// File: rtl/ibex_l2_rf_xfer_ctrl_if.sv
// Bus bundle between the spill/fill engine, the core request logic, the main
// register file and the L2 register file.
//
// Handshake: spill_req_i / fill_req_i are level requests with no ready.
// The engine samples them only while idle. busy_o is the acknowledgement:
// it rises the cycle after a request is taken and stays high until the
// transfer has finished. done_o pulses for one cycle at the end. A request
// that is still high when busy_o falls starts another transfer.
// The RF and L2 ports are plain register-file ports: combinational read
// data, and a write on every clock edge where the write enable is high.
interface ibex_l2_rf_xfer_ctrl_if #(
  parameter int unsigned DataWidth = 32
);

  logic                 spill_req_i;
  logic                 fill_req_i;
  logic                 busy_o;
  logic                 done_o;

  logic [4:0]           rf_raddr_o;
  logic [DataWidth-1:0] rf_rdata_i;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;

  logic [4:0]           l2_addr_o;
  logic [DataWidth-1:0] l2_wdata_o;
  logic                 l2_we_o;
  logic [DataWidth-1:0] l2_rdata_i;

  // Engine side: drives both register-file ports and the status flags.
  modport master (
    input  spill_req_i,
    input  fill_req_i,
    output busy_o,
    output done_o,
    output rf_raddr_o,
    input  rf_rdata_i,
    output rf_waddr_o,
    output rf_wdata_o,
    output rf_we_o,
    output l2_addr_o,
    output l2_wdata_o,
    output l2_we_o,
    input  l2_rdata_i
  );

  // Environment side: core request logic plus the two register files.
  modport slave (
    output spill_req_i,
    output fill_req_i,
    input  busy_o,
    input  done_o,
    input  rf_raddr_o,
    output rf_rdata_i,
    input  rf_waddr_o,
    input  rf_wdata_o,
    input  rf_we_o,
    input  l2_addr_o,
    input  l2_wdata_o,
    input  l2_we_o,
    output l2_rdata_i
  );

endinterface

// File: rtl/ibex_l2_rf_xfer_ctrl.sv
// Context spill/fill engine between the main register file and the L2
// register file. A spill copies x[FirstReg..LastReg] from the main RF into
// the L2 RF, and a fill copies them back, one register per cycle. The read
// data is captured in a single pipeline register before it is written, so
// there is no combinational path from one file's read port to the other
// file's write port.
module ibex_l2_rf_xfer_ctrl #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FirstReg  = 1,
  parameter int unsigned LastReg   = 27
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  ibex_l2_rf_xfer_ctrl_if.master        bus,
  // Current FSM state, for debug and checker binding.
  output logic [1:0]                    state_dbg_o
);

  // The L2 file holds indices 1..27. This keeps the 5-bit index from ever
  // wrapping.
  if (FirstReg < 1 || FirstReg > LastReg || LastReg > 27) begin : gen_bad_params
    $error("ibex_l2_rf_xfer_ctrl: need 1 <= FirstReg <= LastReg <= 27");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    DIR_SPILL = 1'b0,
    DIR_FILL  = 1'b1
  } dir_e;

  localparam logic [4:0] FirstIdx = 5'(FirstReg);
  localparam logic [4:0] LastIdx  = 5'(LastReg);

  state_e               state_q, state_d;
  dir_e                 dir_q;
  logic [4:0]           idx_q;
  logic                 pipe_vld_q;
  logic [4:0]           pipe_addr_q;
  logic [DataWidth-1:0] pipe_data_q;
  logic [DataWidth-1:0] rdata_sel;
  logic                 write_active;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Requests are looked at only in IDLE, so any request
  // raised during a transfer is dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.spill_req_i || bus.fill_req_i) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (idx_q == LastIdx) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Source select for the read side. A spill reads the main RF, and a fill
  // reads the L2 RF.
  always_comb begin
    rdata_sel = (dir_q == DIR_SPILL) ? bus.rf_rdata_i : bus.l2_rdata_i;
  end

  // Direction, read index and pipeline register. Spill wins when both
  // requests are high. idx stops at LastReg and reloads FirstReg in DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q       <= DIR_SPILL;
      idx_q       <= FirstIdx;
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= 5'd0;
      pipe_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.spill_req_i) begin
            dir_q <= DIR_SPILL;
            idx_q <= FirstIdx;
          end else if (bus.fill_req_i) begin
            dir_q <= DIR_FILL;
            idx_q <= FirstIdx;
          end
        end
        XFER: begin
          pipe_data_q <= rdata_sel;
          pipe_addr_q <= idx_q;
          pipe_vld_q  <= 1'b1;
          if (idx_q != LastIdx) begin
            idx_q <= idx_q + 5'd1;
          end
        end
        DRAIN: begin
          pipe_vld_q <= 1'b0;
        end
        DONE: begin
          idx_q <= FirstIdx;
        end
        default: begin
          pipe_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // Port drive. Everything defaults to 0, so idle and unused-direction
  // outputs stay quiet. The L2 address is never wanted twice in one cycle:
  // a spill only writes L2 and a fill only reads it.
  always_comb begin
    bus.rf_raddr_o = 5'd0;
    bus.rf_waddr_o = 5'd0;
    bus.rf_wdata_o = '0;
    bus.rf_we_o    = 1'b0;
    bus.l2_addr_o  = 5'd0;
    bus.l2_wdata_o = '0;
    bus.l2_we_o    = 1'b0;

    write_active = ((state_q == XFER) || (state_q == DRAIN)) && pipe_vld_q;

    if (state_q == XFER) begin
      if (dir_q == DIR_SPILL) begin
        bus.rf_raddr_o = idx_q;
      end else begin
        bus.l2_addr_o = idx_q;
      end
    end

    if (write_active) begin
      if (dir_q == DIR_SPILL) begin
        bus.l2_addr_o  = pipe_addr_q;
        bus.l2_wdata_o = pipe_data_q;
        bus.l2_we_o    = 1'b1;
      end else begin
        bus.rf_waddr_o = pipe_addr_q;
        bus.rf_wdata_o = pipe_data_q;
        bus.rf_we_o    = 1'b1;
      end
    end
  end

  // Status flags decoded straight from the state, so reset clears them at once.
  always_comb begin
    bus.busy_o  = (state_q != IDLE);
    bus.done_o  = (state_q == DONE);
    state_dbg_o = state_q;
  end

endmodule

// File: tb/tb_ibex_l2_rf_xfer_ctrl.sv
// Bench for ibex_l2_rf_xfer_ctrl. Two instances share one clock and one
// reset: instance 0 uses the default register range 1..27, and instance 1
// uses the range 5..7. Each instance has its own main RF and L2 RF arrays.
// Issuing a request pushes the expected writes and the expected done pulse
// into queues. A forked monitor pops and compares them whenever a DUT shows
// a write or a done pulse.
module tb_ibex_l2_rf_xfer_ctrl;

  localparam int W = 55;  // {inst, port(0=L2,1=RF), addr[5], data[32], cycle[16]}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  spill_req, fill_req;
  logic [1:0]  busy, done, rf_we, l2_we;
  logic [4:0]  rf_raddr [2];
  logic [4:0]  rf_waddr [2];
  logic [4:0]  l2_addr  [2];
  logic [31:0] rf_wdata [2];
  logic [31:0] l2_wdata [2];
  logic [1:0]  state_dbg [2];

  logic [31:0] main_rf [2][32];
  logic [31:0] l2_rf   [2][32];
  logic [31:0] ref_main [2][32];
  logic [31:0] ref_l2   [2][32];

  logic [W-1:0] exp_q[$];
  logic [16:0]  exp_done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cycle_cnt = 0;
  int last_t0 = 0;
  int busy_lo [2];
  int busy_hi [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned FR = (g == 0) ? 1 : 5;
    localparam int unsigned LR = (g == 0) ? 27 : 7;

    ibex_l2_rf_xfer_ctrl_if #(.DataWidth(32)) bus ();

    ibex_l2_rf_xfer_ctrl #(
      .DataWidth (32),
      .FirstReg  (FR),
      .LastReg   (LR)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus),
      .state_dbg_o (state_dbg[g])
    );

    assign bus.spill_req_i = spill_req[g];
    assign bus.fill_req_i  = fill_req[g];
    assign bus.rf_rdata_i  = main_rf[g][bus.rf_raddr_o];
    assign bus.l2_rdata_i  = l2_rf[g][bus.l2_addr_o];
    assign busy[g]     = bus.busy_o;
    assign done[g]     = bus.done_o;
    assign rf_we[g]    = bus.rf_we_o;
    assign l2_we[g]    = bus.l2_we_o;
    assign rf_raddr[g] = bus.rf_raddr_o;
    assign rf_waddr[g] = bus.rf_waddr_o;
    assign l2_addr[g]  = bus.l2_addr_o;
    assign rf_wdata[g] = bus.rf_wdata_o;
    assign l2_wdata[g] = bus.l2_wdata_o;
  end

  function automatic int first_reg(input int g);
    return (g == 0) ? 1 : 5;
  endfunction

  function automatic int last_reg(input int g);
    return (g == 0) ? 27 : 7;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h, expected nothing (cycle %0d)", name, act, cycle_cnt);
  endtask

  // Register-file models. The ports are captured mid-cycle and committed on
  // the next rising edge, which is how a real register file behaves.
  task automatic mem_writer();
    logic [1:0]  c_rwe, c_lwe;
    logic [4:0]  c_ra [2];
    logic [4:0]  c_la [2];
    logic [31:0] c_rd [2];
    logic [31:0] c_ld [2];
    forever begin
      @(negedge clk);
      c_rwe = rf_we;
      c_lwe = l2_we;
      for (int g = 0; g < 2; g++) begin
        c_ra[g] = rf_waddr[g];
        c_la[g] = l2_addr[g];
        c_rd[g] = rf_wdata[g];
        c_ld[g] = l2_wdata[g];
      end
      @(posedge clk);
      cycle_cnt++;
      if (rst_n) begin
        for (int g = 0; g < 2; g++) begin
          if (c_rwe[g]) main_rf[g][c_ra[g]] = c_rd[g];
          if (c_lwe[g]) l2_rf[g][c_la[g]]   = c_ld[g];
        end
      end
    end
  endtask

  // Compares DUT activity against the expected queues.
  task automatic monitor();
    logic [W-1:0] got, exp;
    logic [16:0]  dgot, dexp;
    logic         gb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int g = 0; g < 2; g++) begin
          gb = g[0];
          check($sformatf("busy[%0d]", g), 64'(busy[g]),
                64'(cycle_cnt >= busy_lo[g] && cycle_cnt <= busy_hi[g]));
          if (l2_we[g] || rf_we[g]) begin
            check($sformatf("single_we[%0d]", g), 64'(l2_we[g] & rf_we[g]), 64'd0);
            if (rf_we[g])
              got = {gb, 1'b1, rf_waddr[g], rf_wdata[g], cycle_cnt[15:0]};
            else
              got = {gb, 1'b0, l2_addr[g], l2_wdata[g], cycle_cnt[15:0]};
            if (exp_q.size() == 0) begin
              fail_now($sformatf("unexpected_write[%0d]", g), 64'(got));
            end else begin
              exp = exp_q.pop_front();
              check($sformatf("write[%0d]", g), 64'(got), 64'(exp));
            end
          end
          if (done[g]) begin
            dgot = {gb, cycle_cnt[15:0]};
            if (exp_done_q.size() == 0) begin
              fail_now($sformatf("unexpected_done[%0d]", g), 64'(dgot));
            end else begin
              dexp = exp_done_q.pop_front();
              check($sformatf("done[%0d]", g), 64'(dgot), 64'(dexp));
            end
          end
          if (!busy[g]) begin
            check($sformatf("idle_outputs[%0d]", g),
                  64'(|{rf_raddr[g], rf_waddr[g], rf_wdata[g], rf_we[g], l2_addr[g],
                        l2_wdata[g], l2_we[g], done[g], state_dbg[g]}), 64'd0);
          end
        end
      end
    end
  endtask

  // mode 0: 0xA000_0000+i, mode 1: random, mode 2: all zero
  task automatic preload_main(input int g, input int mode);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) begin
      case (mode)
        0:       v = 32'hA000_0000 + 32'(r);
        1:       v = $urandom;
        default: v = 32'h0;
      endcase
      main_rf[g][r]  = v;
      ref_main[g][r] = v;
    end
  endtask

  task automatic preload_l2(input int g);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) begin
      v = $urandom;
      l2_rf[g][r]  = v;
      ref_l2[g][r] = v;
    end
  endtask

  // Starts a transfer with the request held high for one sampling edge.
  // The expected activity comes from the transfer rules alone: register
  // FirstReg+j is written in cycle 2+j, done comes in cycle N+2, and busy is
  // high in cycles 1..N+2. With cut > 0 only the first cut registers are
  // expected, because a reset is coming.
  task automatic start(input int g, input bit sp, input bit fi, input int cut);
    int n, nw, t0, r;
    logic [31:0] v;
    logic gb;
    gb = g[0];
    @(negedge clk);
    spill_req[g] = sp;
    fill_req[g]  = fi;
    @(posedge clk);
    #1;
    t0 = cycle_cnt;
    last_t0 = t0;
    spill_req[g] = 1'b0;
    fill_req[g]  = 1'b0;
    if (!sp && !fi) return;
    n  = last_reg(g) - first_reg(g) + 1;
    nw = (cut > 0) ? cut : n;
    busy_lo[g] = t0;
    busy_hi[g] = (cut > 0) ? t0 + cut : t0 + n + 1;
    for (int j = 0; j < nw; j++) begin
      r = first_reg(g) + j;
      if (sp) begin
        v = ref_main[g][r];
        ref_l2[g][r] = v;
        exp_q.push_back({gb, 1'b0, 5'(r), v, 16'(t0 + 1 + j)});
      end else begin
        v = ref_l2[g][r];
        ref_main[g][r] = v;
        exp_q.push_back({gb, 1'b1, 5'(r), v, 16'(t0 + 1 + j)});
      end
    end
    if (cut == 0) exp_done_q.push_back({gb, 16'(t0 + n + 1)});
  endtask

  task automatic wait_idle(input int g);
    int k;
    k = 0;
    while ((busy[g] || exp_q.size() != 0 || exp_done_q.size() != 0) && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check($sformatf("idle_timeout[%0d]", g), 64'(k < 200), 64'd1);
    check($sformatf("queues_drained[%0d]", g), 64'(exp_q.size() + exp_done_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_mem(input int g);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("main_rf[%0d][%0d]", g, r), 64'(main_rf[g][r]), 64'(ref_main[g][r]));
      check($sformatf("l2_rf[%0d][%0d]", g, r), 64'(l2_rf[g][r]), 64'(ref_l2[g][r]));
    end
  endtask

  initial begin
    int g, op;
    rst_n     = 1'b0;
    spill_req = 2'b00;
    fill_req  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      busy_lo[i] = 1;
      busy_hi[i] = 0;
      preload_main(i, 0);
      preload_l2(i);
    end
    fork
      mem_writer();
      monitor();
    join_none

    // Outputs while reset is held.
    #12;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_busy[%0d]", i), 64'(busy[i]), 64'd0);
      check($sformatf("reset_outputs[%0d]", i),
            64'(|{done[i], rf_we[i], l2_we[i], rf_raddr[i], rf_waddr[i], l2_addr[i],
                  rf_wdata[i], l2_wdata[i]}), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Spill with the default range, then clear the main RF and fill it back.
    start(0, 1'b1, 1'b0, 0);
    wait_idle(0);
    check_mem(0);
    preload_main(0, 2);
    start(0, 1'b0, 1'b1, 0);
    wait_idle(0);
    check_mem(0);

    // Both requests at once: only the spill runs.
    preload_main(0, 1);
    start(0, 1'b1, 1'b1, 0);
    wait_idle(0);
    repeat (4) @(negedge clk);
    check_mem(0);

    // Fill pulsed in the middle of a spill is ignored.
    preload_main(0, 1);
    start(0, 1'b1, 1'b0, 0);
    repeat (9) @(negedge clk);
    fill_req[0] = 1'b1;
    @(negedge clk);
    fill_req[0] = 1'b0;
    wait_idle(0);
    repeat (4) @(negedge clk);
    check_mem(0);

    // Reset at the start of cycle 12 of a spill. Registers 1..10 are already
    // in L2, and register 11 is on the write port when reset hits.
    preload_main(0, 1);
    start(0, 1'b1, 1'b0, 10);
    while (cycle_cnt < last_t0 + 11) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_l2_we", 64'(l2_we[0]), 64'd1);
    check("pre_reset_l2_addr", 64'(l2_addr[0]), 64'd11);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_l2_we", 64'(l2_we[0]), 64'd0);
    check("mid_reset_busy", 64'(busy[0]), 64'd0);
    check("mid_reset_outputs", 64'(|{l2_addr[0], l2_wdata[0], rf_we[0], done[0]}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_reset_queue", 64'(exp_q.size()), 64'd0);
    check_mem(0);
    start(0, 1'b1, 1'b0, 0);
    wait_idle(0);
    check_mem(0);

    // Narrow range 5..7 on instance 1.
    preload_main(1, 0);
    start(1, 1'b1, 1'b0, 0);
    wait_idle(1);
    check_mem(1);
    preload_main(1, 2);
    start(1, 1'b0, 1'b1, 0);
    wait_idle(1);
    check_mem(1);

    // Random mix of instances, operations, data and idle gaps.
    for (int it = 0; it < 10; it++) begin
      g  = $urandom_range(0, 1);
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) preload_main(g, 1);
      if ($urandom_range(0, 3) == 0) preload_l2(g);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start(g, (op != 1), (op != 0), 0);
      wait_idle(g);
      check_mem(g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
